div_norm_unit: RTL and testbench
================================

// Module: div_norm_unit
// PURPOSE
//  Pre-normalization stage directly upstream of the unsigned restoring array divider.
//  - Left-shifts divisor Y until its MSB is set; shifts dividend X by the same amount.
//  - Registers the result behind a valid/ready handshake.
//  - Exports shift amount (for remainder denormalization) and a divide-by-zero flag.
//  - Downstream divider is configured widthX+widthY-1 / widthY; yields full widthX-bit quotient.
// PARAMETERS
//  widthX  16  dividend word width (>=2)
//  widthY  8   divisor word width (>=2, <=widthX)
// PORTS
//  clk_i      in   1                 clock, all state on rising edge
//  rst_ni     in   1                 asynchronous active-low reset
//  valid_i    in   1                 input operands valid
//  ready_o    out  1                 block accepts operands this cycle
//  X          in   widthX            dividend
//  Y          in   widthY            divisor, any value
//  valid_o    out  1                 normalized operands valid
//  ready_i    in   1                 downstream divider stage accepts
//  XN         out  widthX+widthY-1   X << shamt, zero-extended
//  YN         out  widthY            Y << shamt, YN[widthY-1]=1 unless dbz_o
//  shamt_o    out  $clog2(widthY)    applied shift, 0..widthY-1
//  dbz_o      out  1                 Y was zero
// BEHAVIOUR
//  - Reset: state IDLE; valid_o=0, XN=0, YN=0, shamt_o=0, dbz_o=0. ready_o=1 (comb. from IDLE).
//  - Transfer: occurs when valid_i&&ready_o (input) or valid_o&&ready_i (output).
//  - FSM states IDLE, NORM, OUT:
//    IDLE: ready_o=1. On accept: XN={0,X}, YN=Y, shamt=0, dbz=(Y==0).
//          Next state OUT if Y==0 or Y[widthY-1]==1, else NORM.
//    NORM: ready_o=0. Each cycle XN<<=1, YN<<=1, shamt++.
//          Go to OUT in the cycle the shifted YN has its MSB set.
//    OUT:  valid_o=1; XN/YN/shamt_o/dbz_o held stable while ready_i=0.
//          ready_o=ready_i (combinational), giving back-to-back acceptance.
//          ready_i=1 with valid_i=1: load new operands, branch as in IDLE.
//          ready_i=1 with valid_i=0: go to IDLE, valid_o=0 next cycle.
//  - Latency, accept edge to valid_o: 1+shamt cycles (1..widthY).
//  - Y==0: no shifting; shamt_o=0, YN=0, XN={0,X}, dbz_o=1, latency 1.
//  - Width rule: shamt<=widthY-1, so XN never overflows.
//    Top widthY-1 bits of XN are always < YN, so the downstream quotient fits in widthX bits.
//  - Remainder restore (downstream): R = RN >> shamt_o. Quotient needs no correction.
//  - valid_i while busy (NORM) is ignored; upstream must hold it (ready_o=0).
//  - Async reset mid-NORM/OUT: operation dropped; outputs return to reset values immediately.
// CONFIGURATION
//  DIV_NORM_LZC_EN defined:
//    - Leading-zero count computed combinationally on accept; full shift applied in one step.
//    - NORM state unused; latency always 1 cycle; outputs otherwise bit-identical.
//  Not defined:
//    - Iterative 1-bit/cycle shifting as above; smaller area.
// STRUCTURE
//  - Package elau_div_pkg:
//      typedef enum logic [1:0] {IDLE, NORM, OUT} div_norm_state_e;
//      function shamt_width(widthY) = $clog2(widthY).
//  - Sub-module div_norm_lzc (widthY): Y -> lzc, all_zero.
//      Instantiated only under DIV_NORM_LZC_EN.
// TESTING (widthX=16, widthY=8, ready_i=1 unless noted)
//  - X=0x1234, Y=0x80 -> after 1 cycle: XN=0x001234, YN=0x80, shamt_o=0, dbz_o=0.
//  - X=0xFFFF, Y=0x01 -> XN=0x7FFF80, YN=0x80, shamt_o=7.
//      Latency 8 cycles (iterative) / 1 cycle (LZC_EN).
//  - X=0x00AB, Y=0x00 -> after 1 cycle: dbz_o=1, YN=0x00, XN=0x0000AB, shamt_o=0.
//  - X=0x0100, Y=0x03 with ready_i=0 for 5 cycles -> XN=0x004000, YN=0xC0, shamt_o=6.
//      Outputs stable; ready_o=0 until ready_i rises.
//  - Assert rst_ni=0 during NORM (Y=0x01) -> valid_o=0, XN=0, YN=0, shamt_o=0 asynchronously.
//      Next accept after release behaves normally.
//  - Back-to-back Y=0x80, 0x40, 0x20 with valid_i held -> no idle cycle between transfers.
//      shamt_o sequence 0,1,2.
//  - Scoreboard: random X,Y != 0 -> floor(XN/YN)==X/Y and (XN%YN)>>shamt_o==X%Y.

Source files
------------

// File: rtl/elau_div_pkg.sv
// Shared types and helpers for the divider pre-normalization stage.
package elau_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } div_norm_state_e;

    function automatic int shamt_width(input int width_y);
        return $clog2(width_y);
    endfunction

endpackage

// File: rtl/div_norm_lzc.sv
// Leading-zero counter for the divisor; all_zero flags Y==0 (lzc is 0 in that case).
module div_norm_lzc
    import elau_div_pkg::*;
#(
    parameter int widthY = 8
) (
    input  logic [widthY-1:0]                    Y,
    output logic [shamt_width(widthY)-1:0]       lzc,
    output logic                                 all_zero
);

    localparam int SW = shamt_width(widthY);

    // one-hot marker of the most significant set bit
    logic [widthY-1:0] top_set;

    genvar gi;
    generate
        for (gi = 0; gi < widthY; gi++) begin : g_top
            if (gi == widthY - 1) begin : g_msb
                assign top_set[gi] = Y[gi];
            end else begin : g_lower
                assign top_set[gi] = Y[gi] & ~(|Y[widthY-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        lzc = '0;
        for (int i = 0; i < widthY; i++) begin
            if (top_set[i]) begin
                lzc = lzc | SW'(widthY - 1 - i);
            end
        end
    end

    assign all_zero = ~(|Y);

endmodule

// File: rtl/div_norm_unit.sv
// Divisor pre-normalization ahead of the restoring array divider.
// Optional macro DIV_NORM_LZC_EN: single-cycle shift via leading-zero count.
module div_norm_unit
    import elau_div_pkg::*;
#(
    parameter int widthX = 16,
    parameter int widthY = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [widthX-1:0]                   X,
    input  logic [widthY-1:0]                   Y,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [widthX+widthY-2:0]            XN,
    output logic [widthY-1:0]                   YN,
    output logic [shamt_width(widthY)-1:0]      shamt_o,
    output logic                                dbz_o
);

    localparam int SW = shamt_width(widthY);
    localparam int WN = widthX + widthY - 1;

    div_norm_state_e    state_reg, state_next;
    logic [WN-1:0]      xn_reg, xn_next;
    logic [widthY-1:0]  yn_reg, yn_next;
    logic [SW-1:0]      shamt_reg, shamt_next;
    logic               dbz_reg, dbz_next;

    // values captured when a new operand pair is accepted
    logic [WN-1:0]      ld_xn;
    logic [widthY-1:0]  ld_yn;
    logic [SW-1:0]      ld_shamt;
    logic               ld_dbz;
    div_norm_state_e    ld_state;
    logic [WN-1:0]      x_ext;

    assign x_ext = {{(widthY-1){1'b0}}, X};

`ifdef DIV_NORM_LZC_EN
    logic [SW-1:0] lzc;
    logic          all_zero;

    div_norm_lzc #(
        .widthY   (widthY)
    ) u_lzc (
        .Y        (Y),
        .lzc      (lzc),
        .all_zero (all_zero)
    );

    always_comb begin
        ld_xn    = x_ext << lzc;
        ld_yn    = Y << lzc;
        ld_shamt = lzc;
        ld_dbz   = all_zero;
        ld_state = OUT;
    end
`else
    always_comb begin
        ld_xn    = x_ext;
        ld_yn    = Y;
        ld_shamt = '0;
        ld_dbz   = ~(|Y);
        ld_state = ((~(|Y)) || Y[widthY-1]) ? OUT : NORM;
    end
`endif

    always_comb begin
        state_next = state_reg;
        xn_next    = xn_reg;
        yn_next    = yn_reg;
        shamt_next = shamt_reg;
        dbz_next   = dbz_reg;
        ready_o    = 1'b0;
        valid_o    = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next = ld_state;
                    xn_next    = ld_xn;
                    yn_next    = ld_yn;
                    shamt_next = ld_shamt;
                    dbz_next   = ld_dbz;
                end
            end
            NORM: begin
                xn_next    = xn_reg << 1;
                yn_next    = yn_reg << 1;
                shamt_next = shamt_reg + 1'b1;
                // leave once the bit about to become the MSB is set
                if (yn_reg[widthY-2]) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                valid_o = 1'b1;
                ready_o = ready_i;
                if (ready_i) begin
                    if (valid_i) begin
                        state_next = ld_state;
                        xn_next    = ld_xn;
                        yn_next    = ld_yn;
                        shamt_next = ld_shamt;
                        dbz_next   = ld_dbz;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            xn_reg    <= '0;
            yn_reg    <= '0;
            shamt_reg <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            xn_reg    <= xn_next;
            yn_reg    <= yn_next;
            shamt_reg <= shamt_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign XN      = xn_reg;
    assign YN      = yn_reg;
    assign shamt_o = shamt_reg;
    assign dbz_o   = dbz_reg;

endmodule

// File: tb/tb_div_norm_unit.sv
// Directed and scoreboard bench for div_norm_unit (widthX=16, widthY=8).
module tb_div_norm_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] X;
    logic [7:0]  Y;
    logic        valid_o;
    logic        ready_i;
    logic [22:0] XN;
    logic [7:0]  YN;
    logic [2:0]  shamt_o;
    logic        dbz_o;

    int check_count = 0;
    int error_count = 0;

    div_norm_unit #(
        .widthX  (16),
        .widthY  (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .X       (X),
        .Y       (Y),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .XN      (XN),
        .YN      (YN),
        .shamt_o (shamt_o),
        .dbz_o   (dbz_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // present one operand pair, return cycles from accept edge to valid_o
    task automatic launch(input logic [15:0] x, input logic [7:0] y, output int lat);
        X = x;
        Y = y;
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] x, input logic [7:0] y,
                         input logic [22:0] exn, input logic [7:0] eyn,
                         input logic [2:0] esh, input logic edbz, input bit hold);
        int lat;
        int exp_lat;
`ifdef DIV_NORM_LZC_EN
        exp_lat = 1;
`else
        exp_lat = 1 + int'(esh);
`endif
        ready_i = !hold;
        #1;
        check({tag, "_ready_in"}, 64'(ready_o), 64'd1);
        launch(x, y, lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_valid"}, 64'(valid_o), 64'd1);
        check({tag, "_XN"}, 64'(XN), 64'(exn));
        check({tag, "_YN"}, 64'(YN), 64'(eyn));
        check({tag, "_shamt"}, 64'(shamt_o), 64'(esh));
        check({tag, "_dbz"}, 64'(dbz_o), 64'(edbz));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                check({tag, "_hold_ready"}, 64'(ready_o), 64'd0);
                @(posedge clk_i); #1;
                check({tag, "_hold_valid"}, 64'(valid_o), 64'd1);
                check({tag, "_hold_XN"}, 64'(XN), 64'(exn));
                check({tag, "_hold_YN"}, 64'(YN), 64'(eyn));
                check({tag, "_hold_shamt"}, 64'(shamt_o), 64'(esh));
            end
            ready_i = 1'b1;
            #1;
            check({tag, "_release_ready"}, 64'(ready_o), 64'd1);
        end
        @(posedge clk_i); #1;
        check({tag, "_drained"}, 64'(valid_o), 64'd0);
        $display("op %s: X=0x%04h Y=0x%02h -> XN=0x%06h YN=0x%02h shamt=%0d dbz=%0d lat=%0d",
                 tag, x, y, XN, YN, shamt_o, dbz_o, lat);
    endtask

    logic [15:0] bb_x [3];
    logic [7:0]  bb_y [3];
    logic [2:0]  bb_sh [3];

    initial begin
        int in_idx;
        int out_idx;
        int cyc;
        int lat;
        logic [15:0] rx;
        logic [7:0]  ry;
        logic [63:0] q;
        logic [63:0] r;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        X = '0;
        Y = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_XN", 64'(XN), 64'd0);
        check("reset_YN", 64'(YN), 64'd0);
        check("reset_shamt", 64'(shamt_o), 64'd0);
        check("reset_dbz", 64'(dbz_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd1);
        $display("reset: valid=%0d XN=0x%06h YN=0x%02h ready=%0d", valid_o, XN, YN, ready_o);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        do_op("msb_set", 16'h1234, 8'h80, 23'h001234, 8'h80, 3'd0, 1'b0, 1'b0);
        do_op("y_one",   16'hFFFF, 8'h01, 23'h7FFF80, 8'h80, 3'd7, 1'b0, 1'b0);
        do_op("y_zero",  16'h00AB, 8'h00, 23'h0000AB, 8'h00, 3'd0, 1'b1, 1'b0);
        do_op("backpr",  16'h0100, 8'h03, 23'h004000, 8'hC0, 3'd6, 1'b0, 1'b1);

        // asynchronous reset while shifting
        ready_i = 1'b1;
        X = 16'h1234;
        Y = 8'h01;
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_XN", 64'(XN), 64'd0);
        check("arst_YN", 64'(YN), 64'd0);
        check("arst_shamt", 64'(shamt_o), 64'd0);
        check("arst_ready", 64'(ready_o), 64'd1);
        $display("async reset mid-op: valid=%0d XN=0x%06h YN=0x%02h shamt=%0d", valid_o, XN, YN, shamt_o);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        do_op("post_rst", 16'h5555, 8'h01, 23'h2AAA80, 8'h80, 3'd7, 1'b0, 1'b0);

        // back-to-back with valid_i held
        bb_x[0] = 16'h1000; bb_y[0] = 8'h80; bb_sh[0] = 3'd0;
        bb_x[1] = 16'h2001; bb_y[1] = 8'h40; bb_sh[1] = 3'd1;
        bb_x[2] = 16'h0ABC; bb_y[2] = 8'h20; bb_sh[2] = 3'd2;
        ready_i = 1'b1;
        in_idx = 0;
        out_idx = 0;
        cyc = 0;
        X = bb_x[0];
        Y = bb_y[0];
        valid_i = 1'b1;
        #1;
        while (out_idx < 3 && cyc < 60) begin
            logic acc;
            acc = valid_i && ready_o;
            if (valid_o) begin
                check("b2b_shamt", 64'(shamt_o), 64'(bb_sh[out_idx]));
                check("b2b_XN", 64'(XN), 64'({7'd0, bb_x[out_idx]}) << bb_sh[out_idx]);
                if (valid_i) check("b2b_ready", 64'(ready_o), 64'd1);
                $display("b2b out %0d: XN=0x%06h YN=0x%02h shamt=%0d", out_idx, XN, YN, shamt_o);
                out_idx++;
            end
            @(posedge clk_i); #1;
            cyc++;
            if (acc) begin
                in_idx++;
                if (in_idx < 3) begin
                    X = bb_x[in_idx];
                    Y = bb_y[in_idx];
                end else begin
                    valid_i = 1'b0;
                end
            end
        end
        check("b2b_count", 64'(out_idx), 64'd3);
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // scoreboard: quotient and denormalized remainder must match X/Y
        for (int k = 0; k < 20; k++) begin
            rx = 16'($urandom_range(0, 65535));
            ry = 8'($urandom_range(1, 255));
            launch(rx, ry, lat);
            q = 64'(XN) / 64'(YN);
            r = (64'(XN) % 64'(YN)) >> shamt_o;
            check("sb_valid", 64'(valid_o), 64'd1);
            check("sb_ynmsb", 64'(YN[7]), 64'd1);
            check("sb_quot", q, 64'(rx) / 64'(ry));
            check("sb_rem", r, 64'(rx) % 64'(ry));
            $display("sb %0d: X=0x%04h Y=0x%02h XN=0x%06h YN=0x%02h shamt=%0d q=%0d r=%0d",
                     k, rx, ry, XN, YN, shamt_o, q, r);
            @(posedge clk_i); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
